prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Front-end stimulus engine for the pipelined core. It accepts a stream of 32-bit instruction words and writes them into instruction memory starting at a configurable PC. It then releases the core from reset and counts execution cycles up to a budget or an external halt, then freezes the core so register state can be inspected. It sits between the bench/host stream source and the Top-level imem write port and core reset/run controls.

Parameters:
PC_START, 300, byte address of first instruction; also driven on pc_init
DEPTH_WORDS, 256, maximum words accepted per load
RUN_CYCLES, 48, execution cycle budget (0 treated as 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin load (honoured in IDLE and DONE only)
in_valid  in  1  instruction word valid
in_ready  out  1  loader accepts word
in_data  in  32  instruction word
in_last  in  1  marks final word of program
imem_we  out  1  imem write strobe
imem_addr  out  32  imem byte address
imem_wdata  out  32  imem write data
pc_init  out  32  PC reset value for core (constant PC_START)
core_rst_n  out  1  core reset, low holds core in reset
core_run  out  1  high while core executes
halt  in  1  early stop request (RUN only)
cycle_count  out  32  executed cycles
done  out  1  run finished, sticky
err_overflow  out  1  DEPTH_WORDS reached without in_last, sticky

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, imem_we=0, imem_addr=PC_START, imem_wdata=0, core_rst_n=0, core_run=0, cycle_count=0, done=0, err_overflow=0, internal word_cnt=0. pc_init=PC_START always.
- States: IDLE, LOAD, ARM, RUN, DONE.
- IDLE: start -> LOAD; word_cnt=0; write pointer=PC_START.
- LOAD: in_ready=1 (combinational from state). Transfer = in_valid & in_ready. Per transfer, next cycle: imem_we=1, imem_addr=pointer, imem_wdata=in_data; pointer+=4 (32-bit wrap); word_cnt++. No transfer -> imem_we=0 next cycle. Gaps in in_valid are legal; addresses stay contiguous.
- Transfer with in_last -> ARM. Transfer of word DEPTH_WORDS without in_last -> err_overflow=1, DONE (core never released, done=1). in_last on word DEPTH_WORDS -> ARM, no error.
- ARM: single cycle; in_ready=0; final imem write occurs here. -> RUN.
- RUN: core_rst_n=1, core_run=1. First RUN cycle cycle_count=1, +1 per cycle. When cycle_count==RUN_CYCLES or halt=1 (sampled that cycle): next cycle -> DONE, core_run=0, done=1, cycle_count frozen. Both the same cycle: identical result.
- DONE: core_rst_n stays 1 (state preserved for inspection), core_run=0, done=1. start -> LOAD, clearing done, err_overflow, cycle_count; core_rst_n=0 same edge.
- start in LOAD/ARM/RUN ignored. halt outside RUN ignored.
- Reset mid-operation: all outputs return to reset values immediately; already-written imem contents not cleared.

Test Plan:
- Load 3 words (in_last on 3rd), RUN_CYCLES=48 -> imem writes at 300/304/308 with matching data; core_rst_n rises the cycle after the 308 write; core_run high exactly 48 cycles; done=1, cycle_count=48.
- Same program with in_valid toggled 1-0-0-1-0-1 -> still 3 contiguous writes 300/304/308, no extra imem_we pulses.
- DEPTH_WORDS=4, 4 words without in_last -> err_overflow=1, done=1, core_rst_n stays 0, in_ready=0; 5th word not accepted.
- halt asserted at RUN cycle 10 -> cycle_count=10, core_run low next cycle, done=1.
- rst_n pulsed low at RUN cycle 20 -> outputs at reset values immediately, state IDLE; new start loads correctly from 300.
- From DONE, start -> done=0, cycle_count=0, core_rst_n=0, second load and run completes with cycle_count=48.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a program into imem, then runs the core for a bounded number of cycles
module prog_loader #(
  parameter int PC_START    = 300,
  parameter int DEPTH_WORDS = 256,
  parameter int RUN_CYCLES  = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [31:0] pc_init,
  output logic        core_rst_n,
  output logic        core_run,
  input  logic        halt,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        err_overflow
);
  localparam int RC = (RUN_CYCLES == 0) ? 1 : RUN_CYCLES;
  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] ptr, word_cnt;
  logic xfer, full, stop, restart;
  assign in_ready = state == LOAD;
  assign core_run = state == RUN;
  assign done     = state == DONE;
  assign pc_init  = 32'(PC_START);
  assign xfer     = in_valid & in_ready;
  assign full     = word_cnt == 32'(DEPTH_WORDS - 1);
  assign stop     = (cycle_count == 32'(RC)) | halt;
  assign restart  = start & (state == IDLE || state == DONE);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // next-state: load until in_last or the depth limit, one arm cycle, then run until budget or halt
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = (xfer & in_last) ? ARM : (xfer & full) ? DONE : LOAD;
      ARM:     state_nx = RUN;
      RUN:     state_nx = stop ? DONE : RUN;
      DONE:    state_nx = start ? LOAD : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // imem write port, word pointer, core reset release, cycle counter and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we      <= 1'b0;
      imem_addr    <= 32'(PC_START);
      imem_wdata   <= 32'd0;
      ptr          <= 32'(PC_START);
      word_cnt     <= 32'd0;
      core_rst_n   <= 1'b0;
      cycle_count  <= 32'd0;
      err_overflow <= 1'b0;
    end else begin
      imem_we <= xfer;
      if (xfer) begin
        imem_addr  <= ptr;
        imem_wdata <= in_data;
        ptr        <= ptr + 32'd4;
        word_cnt   <= word_cnt + 32'd1;
      end
      if (restart) begin
        ptr          <= 32'(PC_START);
        word_cnt     <= 32'd0;
        core_rst_n   <= 1'b0;
        cycle_count  <= 32'd0;
        err_overflow <= 1'b0;
      end
      if (xfer & full & ~in_last) err_overflow <= 1'b1;
      if (state == ARM) begin
        core_rst_n  <= 1'b1;
        cycle_count <= 32'd1;
      end
      if (state == RUN && !stop) cycle_count <= cycle_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized program loads and runs checked against a transaction-level model
module tb_prog_loader;
  localparam int PC = 300, DW = 4, RC = 48;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0, halt = 0;
  logic [31:0] in_data = 0;
  logic in_ready, imem_we, core_rst_n, core_run, done, err_overflow;
  logic [31:0] imem_addr, imem_wdata, pc_init, cycle_count;
  int checks = 0, errors = 0;
  logic [63:0] wq[$];
  int cyc = 0, last_we = -1, rise_cyc = -1;
  logic prev_rst = 0;

  prog_loader #(.PC_START(PC), .DEPTH_WORDS(DW), .RUN_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc_init(pc_init), .core_rst_n(core_rst_n), .core_run(core_run),
    .halt(halt), .cycle_count(cycle_count), .done(done), .err_overflow(err_overflow));

  always #5 clk = ~clk;

  // log every imem write and the cycle the core reset is released
  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      wq.push_back({imem_addr, imem_wdata});
      last_we = cyc;
    end
    if (core_rst_n && !prev_rst) rise_cyc = cyc;
    prev_rst = core_rst_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst in_ready", in_ready, 0);
    chk("rst imem_we", imem_we, 0);
    chk("rst imem_addr", imem_addr, PC);
    chk("rst imem_wdata", imem_wdata, 0);
    chk("rst core_rst_n", core_rst_n, 0);
    chk("rst core_run", core_run, 0);
    chk("rst cycle_count", cycle_count, 0);
    chk("rst done", done, 0);
    chk("rst err_overflow", err_overflow, 0);
    chk("pc_init", pc_init, PC);
  endtask

  // offer n words, then let it run; halt_at/rst_at are RUN cycle numbers (0 = never)
  task automatic run_prog(input int n, input bit last, input bit gaps, input bit noise,
                          input int halt_at, input int rst_at);
    logic [31:0] data[$];
    int base, acc, guard, run_cnt, exp_acc, exp_cc;
    bit rdy, fin, ovf;
    ovf = !last && n > DW;
    exp_acc = (n > DW) ? DW : n;
    exp_cc = ovf ? 0 : (halt_at > 0 && halt_at < RC) ? halt_at : RC;
    base = wq.size();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("start done", done, 0);
    chk("start cycle_count", cycle_count, 0);
    chk("start core_rst_n", core_rst_n, 0);
    chk("start in_ready", in_ready, 1);
    acc = 0;
    guard = 0;
    while (acc < n && guard < 40) begin
      in_valid = gaps ? 1'($urandom % 2) : 1'b1;
      in_data = $urandom;
      in_last = last && acc == n - 1;
      halt = noise ? 1'($urandom % 2) : 1'b0;
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) begin
        data.push_back(in_data);
        acc++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 0;
    in_last = 0;
    halt = 0;
    chk("accepted words", acc, exp_acc);
    run_cnt = 0;
    fin = 0;
    for (int k = 0; k < 300 && !fin; k++) begin
      if (done) fin = 1;
      else begin
        @(negedge clk);
        if (core_run) run_cnt++;
        halt = core_run && halt_at > 0 && run_cnt == halt_at;
        start = noise && core_run && ($urandom % 2 == 1);
        if (rst_at > 0 && run_cnt == rst_at) begin
          start = 0;
          halt = 0;
          rst_n = 0;
          #1 chk_reset();
          #20 rst_n = 1;
          return;
        end
      end
    end
    start = 0;
    halt = 0;
    chk("done reached", fin, 1);
    chk("run cycles", run_cnt, exp_cc);
    chk("cycle_count", cycle_count, exp_cc);
    chk("err_overflow", err_overflow, ovf);
    chk("core_rst_n done", core_rst_n, !ovf);
    chk("in_ready done", in_ready, 0);
    chk("core_run done", core_run, 0);
    chk("write count", wq.size() - base, acc);
    for (int k = 0; k < acc && base + k < wq.size(); k++) begin
      chk("write addr", wq[base + k][63:32], PC + 4 * k);
      chk("write data", wq[base + k][31:0], data[k]);
    end
    if (!ovf) chk("release after last write", rise_cyc - last_we, 1);
    repeat (3) @(negedge clk);
    chk("cycle_count frozen", cycle_count, exp_cc);
    chk("done sticky", done, 1);
  endtask

  initial begin
    int n;
    bit last;
    #12 chk_reset();
    rst_n = 1;
    run_prog(3, 1, 0, 0, 0, 0);
    run_prog(3, 1, 1, 0, 0, 0);
    run_prog(5, 0, 0, 0, 0, 0);
    run_prog(3, 1, 0, 0, 10, 0);
    run_prog(3, 1, 0, 0, 0, 20);
    run_prog(3, 1, 0, 0, 0, 0);
    run_prog(4, 1, 1, 1, 0, 0);
    run_prog(1, 1, 0, 0, 1, 0);
    run_prog(2, 1, 0, 0, 48, 0);
    for (int i = 0; i < 6; i++) begin
      last = $urandom % 4 != 0;
      n = last ? $urandom_range(1, DW) : DW + 1;
      run_prog(n, last, 1, 1, ($urandom % 2 == 1) ? $urandom_range(1, 60) : 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
